// File: rtl/apb_master_bridge_if.sv
// Command/response and APB signal bundle for apb_master_bridge.
// A command transfers on a rising PCLK edge where req_valid and req_ready are both 1; the caller holds its fields stable until then.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: one valid/ready command becomes one SETUP/ACCESS
// transfer and produces one response (read data or timeout).
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          // Reads leave PWDATA at the last written value.
          if (bus.req_write) pwdata_d = bus.req_wdata;
          cnt_d   = '0;
          psel_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          // Saturates only when the timeout is disabled.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: memory completer with programmable wait states,
// table vectors, corner-case sequences and a randomized run against a reference model.
module tb_apb_master_bridge;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic       PCLK;
  logic       PRESET;
  logic [1:0] dbg_state;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // completer: memory, PREADY raised after wait_cfg ACCESS cycles
  logic [DW-1:0] cmem [256];
  int            wait_cfg;
  int            acc_cnt;

  assign bus.PREADY = bus.PSEL && bus.PENABLE && (acc_cnt >= wait_cfg);
  assign bus.PRDATA = cmem[bus.PADDR];

  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) cmem[bus.PADDR] <= bus.PWDATA;
  end

  // scoreboard / reference model
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] last_wd;
  int vectors;
  int miscompares;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ACCESS-cycle count for a completer that inserts `waits` wait states.
  function automatic int model_access(input int waits);
    return (waits < TO) ? waits + 1 : TO;
  endfunction

  // Issue one command and follow it to its response; expectation is taken from exp_q.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int waits, input int exp_acc);
    int lat, acc, setup, stable_err;
    bit got;
    logic [DW:0] exp;
    @(negedge PCLK);
    chk("rsp_single_cycle", bus.rsp_valid, 1'b0);
    wait_cfg      = waits;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    chk("req_ready_idle", bus.req_ready, 1'b1);
    @(posedge PCLK);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    lat = 1; acc = 0; setup = 0; stable_err = 0; got = 0;
    while (!got && lat < 64) begin
      if (bus.rsp_valid) got = 1;
      else begin
        if (bus.PSEL && !bus.PENABLE) setup++;
        if (bus.PENABLE && !bus.PSEL) stable_err++;
        if (bus.PSEL && bus.PENABLE) begin
          acc++;
          if (bus.PADDR !== addr || bus.PWRITE !== wr) stable_err++;
          if (bus.PWDATA !== (wr ? wd : last_wd)) stable_err++;
        end
        @(negedge PCLK);
        lat++;
      end
    end
    chk("rsp_seen", got, 1'b1);
    if (wr) last_wd = wd;
    if (got) begin
      chk("setup_cycles", setup, 1);
      chk("access_cycles", acc, exp_acc);
      chk("latency", lat, exp_acc + 2);
      chk("bus_stable", stable_err, 0);
      chk("psel_low_at_rsp", bus.PSEL, 1'b0);
      chk("req_ready_at_rsp", bus.req_ready, 1'b1);
      chk("scoreboard_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        chk("rsp_timeout", bus.rsp_timeout, exp[DW]);
        chk("rsp_rdata", bus.rsp_rdata, exp[DW-1:0]);
      end
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            waits;
    logic          exp_to;
    logic [DW-1:0] exp_rd;
    int            exp_acc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int rv_cyc[$];
    int first_hi, last_hi, lows, idx;
    bit pend;
    bit psel_hist [32];

    tbl[0] = '{1'b1, 8'h3C, 32'hDEADBEEF, 0,   1'b0, 32'h0,        1};
    tbl[1] = '{1'b0, 8'h3C, 32'h0,        0,   1'b0, 32'hDEADBEEF, 1};
    tbl[2] = '{1'b1, 8'h20, 32'h12345678, 2,   1'b0, 32'h0,        3};
    tbl[3] = '{1'b0, 8'h20, 32'h0,        4,   1'b0, 32'h12345678, 5};
    tbl[4] = '{1'b0, 8'h10, 32'h0,        200, 1'b1, 32'h0,        16};
    tbl[5] = '{1'b1, 8'h10, 32'h00000055, 1,   1'b0, 32'h0,        2};
    tbl[6] = '{1'b0, 8'h10, 32'h0,        0,   1'b0, 32'h00000055, 1};

    vectors = 0; miscompares = 0; last_wd = '0;
    for (int i = 0; i < 256; i++) begin
      cmem[i] = '0;
      model_mem[i] = '0;
    end
    wait_cfg = 0; acc_cnt = 0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // reset then idle
    PRESET = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("rst_psel", bus.PSEL, 1'b0);
      chk("rst_penable", bus.PENABLE, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, '0);
      chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
      chk("rst_paddr", bus.PADDR, '0);
      chk("rst_pwdata", bus.PWDATA, '0);
      chk("rst_pwrite", bus.PWRITE, 1'b0);
    end
    PRESET = 1'b1;
    repeat (10) begin
      @(negedge PCLK);
      chk("idle_psel", bus.PSEL, 1'b0);
      chk("idle_penable", bus.PENABLE, 1'b0);
      chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
      chk("idle_req_ready", bus.req_ready, 1'b1);
    end

    // table vectors
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({tbl[i].exp_to, tbl[i].exp_rd});
      do_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].waits, tbl[i].exp_acc);
      if (tbl[i].wr && !tbl[i].exp_to) model_mem[tbl[i].addr] = tbl[i].wd;
    end

    // back-to-back writes with req_valid held high
    wait_cfg = 0; first_hi = -1; last_hi = -1; idx = 0; pend = 0;
    @(negedge PCLK);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = 8'h00; bus.req_wdata = 32'hA0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge PCLK);
      if (pend) begin
        pend = 0;
        idx++;
        if (idx < 4) begin
          bus.req_addr  = AW'(idx);
          bus.req_wdata = 32'hA0 + DW'(idx);
        end else bus.req_valid = 1'b0;
      end
      psel_hist[c] = bus.PSEL;
      if (bus.PSEL) begin
        if (first_hi < 0) first_hi = c;
        last_hi = c;
      end
      if (bus.rsp_valid) begin
        rv_cyc.push_back(c);
        chk("b2b_rsp_rdata", bus.rsp_rdata, '0);
        chk("b2b_rsp_timeout", bus.rsp_timeout, 1'b0);
      end
      if (bus.req_valid && bus.req_ready) pend = 1;
    end
    for (int i = 0; i < 4; i++) model_mem[i] = 32'hA0 + DW'(i);
    last_wd = 32'hA3;
    chk("b2b_rsp_count", rv_cyc.size(), 4);
    for (int i = 1; i < rv_cyc.size(); i++) chk("b2b_rsp_spacing", rv_cyc[i] - rv_cyc[i-1], 3);
    lows = 0;
    if (first_hi >= 0)
      for (int c = first_hi; c <= last_hi; c++) if (!psel_hist[c]) lows++;
    chk("b2b_idle_gaps", lows, 3);
    chk("b2b_span", last_hi - first_hi, 10);

    // reset in the middle of ACCESS
    @(negedge PCLK);
    wait_cfg = 100;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h3C;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 5 && !bus.PENABLE; k++) @(negedge PCLK);
    chk("mid_penable_seen", bus.PENABLE, 1'b1);
    #1 PRESET = 1'b0;
    #1;
    chk("mid_rst_psel", bus.PSEL, 1'b0);
    chk("mid_rst_penable", bus.PENABLE, 1'b0);
    repeat (3) begin
      @(negedge PCLK);
      chk("mid_rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    PRESET = 1'b1;
    last_wd = '0;
    repeat (2) begin
      @(negedge PCLK);
      chk("post_rst_no_rsp", bus.rsp_valid, 1'b0);
      chk("post_rst_psel", bus.PSEL, 1'b0);
    end
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    do_cmd(1'b0, 8'h3C, 32'h0, 0, model_access(0));

    // randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      int            waits;
      wr    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 15));
      wd    = $urandom;
      waits = ($urandom_range(0, 9) == 9) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 3);
      if (waits >= TO) exp_q.push_back({1'b1, 32'h0});
      else if (wr) exp_q.push_back({1'b0, 32'h0});
      else exp_q.push_back({1'b0, model_mem[addr]});
      do_cmd(wr, addr, wd, waits, model_access(waits));
      if (wr && waits < TO) model_mem[addr] = wd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
